// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises and word-debounces eight panel switches, emitting a stable word and update strobe
module switch_debouncer #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_raw,
  output logic [7:0] sw_stable,
  output logic       upd,
  output logic       busy
);
  typedef enum logic {IDLE, COUNT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);
  state_t state, next_state;
  logic [7:0] s1, s2, snap, snap_n, stable_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic upd_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      snap <= '0;
      sw_stable <= '0;
      cnt <= '0;
      upd <= 1'b0;
      state <= IDLE;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      snap <= snap_n;
      sw_stable <= stable_n;
      cnt <= cnt_n;
      upd <= upd_n;
      state <= next_state;
    end
  end
  // any differing bit restarts timing, so multi-bit changes commit as one word
  always_comb begin
    next_state = state;
    snap_n = snap;
    cnt_n = cnt;
    stable_n = sw_stable;
    upd_n = 1'b0;
    if (state == IDLE) begin
      if (s2 != sw_stable) begin
        next_state = COUNT;
        snap_n = s2;
        cnt_n = '0;
      end
    end else if (s2 == sw_stable) begin
      next_state = IDLE;
      cnt_n = '0;
    end else if (s2 != snap) begin
      snap_n = s2;
      cnt_n = '0;
    end else if (cnt == LAST) begin
      next_state = IDLE;
      stable_n = snap;
      upd_n = 1'b1;
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_comb busy = (state == COUNT);
endmodule
